// File: rtl/tile_types_pkg.sv
// Tile code constants shared by the tile RAM writer, the renderer and the
// sprite ROM address generator, plus the rotation-animation constants.
package tile_types_pkg;

  // Board tile codes referenced by the render path (full table runs 0..87)
  localparam int BOARD_EMPTY         = 0;
  localparam int BOARD_TRIANG        = 2;
  localparam int BOARD_CIRCLE        = 7;
  localparam int TEXT_CIRC_WON_MSG_8 = 87;

  // Rotation animation: five frames stored as consecutive ROM tiles
  localparam int ANIM_FRAMES    = 5;
  localparam int ANIM_BASE_TRI  = BOARD_TRIANG;
  localparam int ANIM_BASE_CIRC = BOARD_CIRCLE;

  typedef logic [2:0] animFrame_t;

  // Only the first tile of each rotating shape is animated; its rotated
  // frames (3..6, 8..11) are addressed directly and always stay static.
  function automatic logic isAnimBase(input int unsigned code);
    return (code == ANIM_BASE_TRI) || (code == ANIM_BASE_CIRC);
  endfunction

endpackage

// File: rtl/tile_anim_frame_ctr.sv
// Animation frame counter: divides the per-frame vsync tick by ANIM_PERIOD
// and steps the rotation frame 0..ANIM_FRAMES-1, wrapping back to 0.
module tile_anim_frame_ctr
  import tile_types_pkg::*;
#(
  parameter int ANIM_PERIOD = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       anim_en_i,
  input  logic       frame_tick_i,
  output animFrame_t frame_o
);

  localparam int TICK_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(ANIM_PERIOD - 1);
  localparam animFrame_t        FRAME_LAST = animFrame_t'(ANIM_FRAMES - 1);

  generate
    if (ANIM_PERIOD < 1) begin : gBadPeriod
      $error("tile_anim_frame_ctr: ANIM_PERIOD must be at least 1");
    end
  endgenerate

  logic [TICK_W-1:0] tickCnt_q, tickCnt_d;
  animFrame_t        frame_q, frame_d;

  // Next-state: disabling animation parks the shapes on frame 0 and restarts
  // the tick divider, so re-enabling always begins a full period from frame 0.
  always_comb begin
    tickCnt_d = tickCnt_q;
    frame_d   = frame_q;
    if (!anim_en_i) begin
      tickCnt_d = '0;
      frame_d   = '0;
    end else if (frame_tick_i) begin
      if (tickCnt_q == TICK_LAST) begin
        tickCnt_d = '0;
        frame_d   = (frame_q == FRAME_LAST) ? animFrame_t'(0) : frame_q + animFrame_t'(1);
      end else begin
        tickCnt_d = tickCnt_q + TICK_W'(1);
      end
    end
  end

  // Counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tickCnt_q <= '0;
      frame_q   <= '0;
    end else begin
      tickCnt_q <= tickCnt_d;
      frame_q   <= frame_d;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/tile_pixel_rom_addr_gen.sv
// Sprite ROM pixel address generator: maps (tile code, pixel x/y) to
// {tile_index, py, px} through a two-stage valid/ready pipeline. Stage 1
// range-checks the code and applies the rotation frame, stage 2 composes
// and holds the ROM address for the sprite ROM.
module tile_pixel_rom_addr_gen
  import tile_types_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 7,
  parameter int TILE_W_LOG2    = 3,
  parameter int TILE_H_LOG2    = 3,
  parameter int NUM_TILES      = 88,
  parameter int ANIM_PERIOD    = 8,
  parameter int ROM_ADDR_WIDTH = 13
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [RAM_DATA_WIDTH-1:0] tile_type_i,
  input  logic [TILE_W_LOG2-1:0]    px_i,
  input  logic [TILE_H_LOG2-1:0]    py_i,
  input  logic                      anim_en_i,
  input  logic                      frame_tick_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [ROM_ADDR_WIDTH-1:0] addr_o,
  output logic                      bad_o,
  output logic                      err_o
);

  generate
    if (ROM_ADDR_WIDTH != RAM_DATA_WIDTH + TILE_W_LOG2 + TILE_H_LOG2) begin : gBadWidth
      $error("tile_pixel_rom_addr_gen: ROM_ADDR_WIDTH must equal RAM_DATA_WIDTH+TILE_W_LOG2+TILE_H_LOG2");
    end
  endgenerate

  animFrame_t frame;
  logic       s1Adv;
  logic       accept;
  logic       codeBad;
  logic       animHit;
  logic [RAM_DATA_WIDTH-1:0] decIndex;

  logic                      s1Valid_q, s1Valid_d;
  logic [RAM_DATA_WIDTH-1:0] s1Index_q, s1Index_d;
  logic [TILE_H_LOG2-1:0]    s1Py_q, s1Py_d;
  logic [TILE_W_LOG2-1:0]    s1Px_q, s1Px_d;
  logic                      s1Bad_q, s1Bad_d;

  logic                      valid_q, valid_d;
  logic [ROM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      bad_q, bad_d;
  logic                      err_q, err_d;

  tile_anim_frame_ctr #(
    .ANIM_PERIOD (ANIM_PERIOD)
  ) uFrameCtr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .anim_en_i    (anim_en_i),
    .frame_tick_i (frame_tick_i),
    .frame_o      (frame)
  );

  // Stage 2 advances whenever its slot is free or being drained; stage 1 can
  // take a new request when empty or when its beat moves on this cycle.
  assign s1Adv   = ~valid_q | ready_i;
  assign ready_o = ~s1Valid_q | s1Adv;
  assign accept  = valid_i & ready_o;

  // Decode the incoming code: illegal codes render as an empty board tile,
  // rotating shapes pick up the frame current at the moment of acceptance.
  always_comb begin
    codeBad  = (32'(tile_type_i) >= 32'(NUM_TILES));
    animHit  = anim_en_i && isAnimBase(32'(tile_type_i));
    decIndex = tile_type_i;
    if (codeBad) begin
      decIndex = '0;
    end else if (animHit) begin
      decIndex = tile_type_i + RAM_DATA_WIDTH'(frame);
    end
  end

  // Stage 1 next-state: load the decoded beat whenever the slot opens up
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Index_d = s1Index_q;
    s1Py_d    = s1Py_q;
    s1Px_d    = s1Px_q;
    s1Bad_d   = s1Bad_q;
    if (ready_o) begin
      s1Valid_d = valid_i;
      if (valid_i) begin
        s1Index_d = decIndex;
        s1Py_d    = py_i;
        s1Px_d    = px_i;
        s1Bad_d   = codeBad;
      end
    end
  end

  // Stage 2 next-state: address and bad flag only change when the output
  // slot advances, so they stay frozen while the sprite ROM side stalls.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    bad_d   = bad_q;
    if (s1Adv) begin
      valid_d = s1Valid_q;
      if (s1Valid_q) begin
        addr_d = {s1Index_q, s1Py_q, s1Px_q};
        bad_d  = s1Bad_q;
      end
    end
  end

  // Sticky error: remembers any illegal code taken in since reset
  always_comb begin
    err_d = err_q | (accept & codeBad);
  end

  // Pipeline and status registers; reset empties both stages
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Valid_q <= 1'b0;
      s1Index_q <= '0;
      s1Py_q    <= '0;
      s1Px_q    <= '0;
      s1Bad_q   <= 1'b0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      bad_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Index_q <= s1Index_d;
      s1Py_q    <= s1Py_d;
      s1Px_q    <= s1Px_d;
      s1Bad_q   <= s1Bad_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      bad_q     <= bad_d;
      err_q     <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign bad_o   = bad_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_tile_pixel_rom_addr_gen.sv
// Self-checking bench for tile_pixel_rom_addr_gen. A negedge monitor keeps a
// reference model of accepted beats (expected queue) and records every beat
// delivered downstream (observed queue); scenario tasks compare them.
module tb_tile_pixel_rom_addr_gen;

  localparam int RDW = 7;
  localparam int TW  = 3;
  localparam int TH  = 3;
  localparam int NT  = 88;
  localparam int AP  = 8;
  localparam int AW  = 13;

  logic clk = 1'b0;
  logic rst;
  logic validIn, readyOut, animEn, frameTick, validOut, readyIn, badOut, errOut;
  logic [RDW-1:0] tileType;
  logic [TW-1:0]  px;
  logic [TH-1:0]  py;
  logic [AW-1:0]  addrOut;

  int checks = 0;
  int errors = 0;

  logic [AW:0] expQ[$];
  logic [AW:0] obsQ[$];
  int modelTicks = 0;
  bit errModel = 1'b0;

  always #5 clk = ~clk;

  tile_pixel_rom_addr_gen #(
    .RAM_DATA_WIDTH (RDW),
    .TILE_W_LOG2    (TW),
    .TILE_H_LOG2    (TH),
    .NUM_TILES      (NT),
    .ANIM_PERIOD    (AP),
    .ROM_ADDR_WIDTH (AW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .valid_i      (validIn),
    .ready_o      (readyOut),
    .tile_type_i  (tileType),
    .px_i         (px),
    .py_i         (py),
    .anim_en_i    (animEn),
    .frame_tick_i (frameTick),
    .valid_o      (validOut),
    .ready_i      (readyIn),
    .addr_o       (addrOut),
    .bad_o        (badOut),
    .err_o        (errOut)
  );

  // Reference: frame is the number of whole animation periods elapsed since
  // animation was (re)enabled, modulo the five frames; returns {bad, addr}.
  function automatic logic [AW:0] refBeat(int code, int x, int y, bit animOn, int ticks);
    int frame;
    int idx;
    bit bad;
    frame = (ticks / AP) % 5;
    bad   = (code >= NT);
    if (bad) idx = 0;
    else if (animOn && (code == 2 || code == 7)) idx = code + frame;
    else idx = code;
    return {bad, AW'(idx * (1 << (TW + TH)) + y * (1 << TW) + x)};
  endfunction

  // Monitor: inputs and outputs are stable mid-cycle, so what is seen here is
  // exactly what the next rising edge will transfer.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      obsQ.delete();
      modelTicks = 0;
      errModel   = 1'b0;
    end else begin
      if (validOut && readyIn) obsQ.push_back({badOut, addrOut});
      if (validIn && readyOut) begin
        expQ.push_back(refBeat(int'(tileType), int'(px), int'(py), animEn, modelTicks));
        if (int'(tileType) >= NT) errModel = 1'b1;
      end
      if (!animEn) modelTicks = 0;
      else if (frameTick) modelTicks++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int code, input int x, input int y);
    validIn  = v;
    tileType = RDW'(code);
    px       = TW'(x);
    py       = TH'(y);
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 0, 0, 0);
    frameTick = 1'b0;
    readyIn   = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic pulseTicks(input int n);
    for (int i = 0; i < n; i++) begin
      frameTick = 1'b1;
      cycle();
      frameTick = 1'b0;
      cycle();
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({validOut, badOut, errOut, addrOut} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%0b bad=%0b err=%0b addr=0x%03h, want all 0", validOut, badOut, errOut, addrOut);
    end
    rst = 1'b0;
    readyIn = 1'b1;
    applyStimulus(1'b1, 120, 2, 2);
    cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, $urandom_range(0, NT - 1), $urandom_range(0, 7), $urandom_range(0, 7));
      readyIn = (i < 2);
      cycle();
    end
    checks++;
    if (errOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_before_reset: err=%0b, want 1", errOut);
    end
    rst = 1'b1;
    applyStimulus(1'b1, 9, 1, 1);
    cycle();
    checks++;
    if (validOut !== 1'b0 || errOut !== 1'b0 || addrOut !== '0) begin
      errors++;
      $display("[TB] FAIL midstream_reset: valid=%0b err=%0b addr=0x%03h, want 0 0 0x000", validOut, errOut, addrOut);
    end
    repeat (2) cycle();
    rst = 1'b0;
    idle(6);
    checks++;
    if (obsQ.size() != 0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL stale_after_reset: delivered=%0d pending=%0d, want 0 0", obsQ.size(), expQ.size());
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_mapping();
    int highCnt;
    animEn = 1'b0;
    applyStimulus(1'b1, 12, 5, 3);
    cycle();
    applyStimulus(1'b0, 0, 0, 0);
    checks++;
    if (validOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL map_latency1: valid=%0b, want 0", validOut);
    end
    cycle();
    checks++;
    if (validOut !== 1'b1 || addrOut !== 13'h31D || badOut !== 1'b0) begin
      errors++;
      $display("[TB] FAIL map_code12: valid=%0b addr=0x%03h bad=%0b, want 1 0x31d 0", validOut, addrOut, badOut);
    end
    idle(4);
    expQ.delete();
    obsQ.delete();
    highCnt = 0;
    for (int i = 0; i < 90; i++) begin
      if (i < NT) applyStimulus(1'b1, i, $urandom_range(0, 7), $urandom_range(0, 7));
      else applyStimulus(1'b0, 0, 0, 0);
      cycle();
      if (validOut) highCnt++;
    end
    checks++;
    if (highCnt != NT) begin
      errors++;
      $display("[TB] FAIL b2b_valid_cycles: got %0d, want %0d", highCnt, NT);
    end
    idle(4);
    checks++;
    if (obsQ.size() != NT) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d, want %0d", obsQ.size(), NT);
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i] || int'(obsQ[i][AW-1 -: RDW]) != i) begin
        errors++;
        $display("[TB] FAIL b2b_beat %0d: got {bad,addr}=0x%04h, want 0x%04h index %0d", i, obsQ[i], expQ[i], i);
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_range();
    applyStimulus(1'b1, 100, 1, 1);
    cycle();
    applyStimulus(1'b0, 0, 0, 0);
    checks++;
    if (errOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL range_err_set: err=%0b, want 1", errOut);
    end
    cycle();
    checks++;
    if (validOut !== 1'b1 || addrOut !== 13'h009 || badOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL range_code100: valid=%0b addr=0x%03h bad=%0b, want 1 0x009 1", validOut, addrOut, badOut);
    end
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, $urandom_range(0, 127), $urandom_range(0, 7), $urandom_range(0, 7));
      cycle();
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, $urandom_range(12, NT - 1), 0, 0);
      cycle();
    end
    idle(4);
    checks++;
    if (errOut !== 1'b1) begin
      errors++;
      $display("[TB] FAIL range_err_sticky: err=%0b, want 1", errOut);
    end
    checks++;
    if (obsQ.size() != expQ.size() || obsQ.size() != 46) begin
      errors++;
      $display("[TB] FAIL range_count: got %0d, want %0d", obsQ.size(), 46);
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL range_beat %0d: got {bad,addr}=0x%04h, want 0x%04h", i, obsQ[i], expQ[i]);
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_animation();
    logic [AW-1:0] triExp [6];
    triExp = '{13'h080, 13'h0C0, 13'h100, 13'h140, 13'h180, 13'h080};
    animEn = 1'b0;
    idle(1);
    animEn = 1'b1;
    for (int s = 0; s < 6; s++) begin
      applyStimulus(1'b1, 2, 0, 0);
      cycle();
      applyStimulus(1'b1, 3, 0, 0);
      cycle();
      applyStimulus(1'b0, 0, 0, 0);
      pulseTicks(AP);
    end
    idle(4);
    checks++;
    if (obsQ.size() != 12) begin
      errors++;
      $display("[TB] FAIL anim_count: got %0d, want 12", obsQ.size());
    end
    for (int s = 0; s < 6 && 2 * s + 1 < obsQ.size(); s++) begin
      checks++;
      if (obsQ[2*s] !== {1'b0, triExp[s]} || obsQ[2*s+1] !== {1'b0, 13'h0C0}) begin
        errors++;
        $display("[TB] FAIL anim_step %0d: got tri=0x%03h static=0x%03h, want 0x%03h 0x0c0", s, obsQ[2*s][AW-1:0], obsQ[2*s+1][AW-1:0], triExp[s]);
      end
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL anim_model %0d: got 0x%04h, want 0x%04h", i, obsQ[i], expQ[i]);
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_backpressure();
    int sent;
    bit sawStall;
    logic [AW:0] want;
    animEn = 1'b0;
    sent = 0;
    sawStall = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      readyIn = !(cyc >= 2 && cyc < 6);
      if (sent < 6) applyStimulus(1'b1, 20 + sent, $urandom_range(0, 7), $urandom_range(0, 7));
      else applyStimulus(1'b0, 0, 0, 0);
      #1;
      if (!readyIn) begin
        if (!readyOut) sawStall = 1'b1;
        want = (obsQ.size() < expQ.size()) ? expQ[obsQ.size()] : '1;
        checks++;
        if (validOut !== 1'b1 || {badOut, addrOut} !== want) begin
          errors++;
          $display("[TB] FAIL bp_hold cyc %0d: valid=%0b {bad,addr}=0x%04h, want 1 0x%04h", cyc, validOut, {badOut, addrOut}, want);
        end
      end
      if (validIn && readyOut) sent++;
      @(posedge clk);
      #1;
    end
    idle(4);
    checks++;
    if (!sawStall || sent != 6) begin
      errors++;
      $display("[TB] FAIL bp_stall: ready_low_seen=%0b sent=%0d, want 1 6", sawStall, sent);
    end
    checks++;
    if (obsQ.size() != 6) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d, want 6", obsQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i] || int'(obsQ[i][AW-1 -: RDW]) != 20 + i) begin
        errors++;
        $display("[TB] FAIL bp_beat %0d: got 0x%04h, want 0x%04h index %0d", i, obsQ[i], expQ[i], 20 + i);
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_concurrency();
    logic [AW-1:0] want [4];
    want = '{13'h1C0, 13'h200, 13'h1C0, 13'h200};
    animEn = 1'b0;
    idle(1);
    animEn = 1'b1;
    pulseTicks(AP - 1);
    applyStimulus(1'b1, 7, 0, 0);
    frameTick = 1'b1;
    cycle();
    frameTick = 1'b0;
    cycle();
    animEn = 1'b0;
    cycle();
    applyStimulus(1'b0, 0, 0, 0);
    animEn = 1'b1;
    pulseTicks(AP);
    applyStimulus(1'b1, 7, 0, 0);
    cycle();
    idle(4);
    checks++;
    if (obsQ.size() != 4) begin
      errors++;
      $display("[TB] FAIL conc_count: got %0d, want 4", obsQ.size());
    end
    for (int i = 0; i < 4 && i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== {1'b0, want[i]} || obsQ[i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL conc_beat %0d: got 0x%03h, want 0x%03h", i, obsQ[i][AW-1:0], want[i]);
      end
    end
    expQ.delete();
    obsQ.delete();
  endtask

  task automatic test_back_to_back();
    int code;
    for (int i = 0; i < 400; i++) begin
      code = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? 2 : 7) : $urandom_range(0, 127);
      applyStimulus($urandom_range(0, 3) != 0, code, $urandom_range(0, 7), $urandom_range(0, 7));
      readyIn   = ($urandom_range(0, 3) != 0);
      frameTick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) animEn = ~animEn;
      cycle();
    end
    animEn = 1'b1;
    idle(6);
    checks++;
    if (obsQ.size() != expQ.size() || obsQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d, want %0d", obsQ.size(), expQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin
        errors++;
        $display("[TB] FAIL rand_beat %0d: got 0x%04h, want 0x%04h", i, obsQ[i], expQ[i]);
      end
    end
    checks++;
    if (errOut !== errModel) begin
      errors++;
      $display("[TB] FAIL rand_err: got %0b, want %0b", errOut, errModel);
    end
    expQ.delete();
    obsQ.delete();
  endtask

  // Scenario sequence: power-on reset, then each feature in turn
  initial begin
    rst       = 1'b1;
    readyIn   = 1'b1;
    animEn    = 1'b0;
    frameTick = 1'b0;
    applyStimulus(1'b0, 0, 0, 0);
    repeat (2) cycle();
    test_reset();
    test_mapping();
    test_range();
    test_animation();
    test_backpressure();
    test_concurrency();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
